// File: rtl/uart_pkg.sv
// Shared types and register map for the parametrised UART controller.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_e;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_BAUD     = 3'd1;
  localparam logic [2:0] REG_TXDATA   = 3'd2;
  localparam logic [2:0] REG_RXDATA   = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;
  localparam logic [2:0] REG_IRQ_EN   = 3'd5;
  localparam logic [2:0] REG_IRQ_STAT = 3'd6;

  typedef struct packed {
    logic [3:0] rx_thresh;
    logic       stop2;
    logic       par_odd;
    logic       par_en;
    logic       rx_en;
    logic       tx_en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_to_word(ctrl_t c);
    return {20'b0, c.rx_thresh, 3'b0, c.stop2, c.par_odd, c.par_en, c.rx_en, c.tx_en};
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with level output; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          do_push;
  logic          do_pop;

  assign full     = (level_reg == (AW+1)'(DEPTH));
  assign empty    = (level_reg == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr_reg];
  assign level    = level_reg;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/uart_ctrl_param.sv
// Parametrised UART controller: register bus, TX/RX FIFOs, baud tick divider,
// programmable-frame transmitter and mid-bit oversampling receiver.
module uart_ctrl_param
  import uart_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int OVS      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_en,
  input  logic        r_en,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        ready,
  output logic        slverr,
  output logic        tx,
  input  logic        rx,
  output logic        interrupt
);
  localparam int CNT_W = $clog2(OVS);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int TXL_W = $clog2(TX_DEPTH) + 1;
  localparam int RXL_W = $clog2(RX_DEPTH) + 1;
  localparam int RXW   = DATA_W + 2;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVS - 1);
  localparam logic [CNT_W-1:0] MID_LAST  = CNT_W'(OVS / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

  ctrl_t       ctrl_reg;
  logic [15:0] baud_div_reg, baud_cnt_reg;
  logic [3:0]  irq_en_reg;
  logic        ovr_sticky_reg, err_sticky_reg;
  logic [31:0] r_data_reg, r_data_next;
  logic        ready_reg, slverr_reg, slverr_next;
  logic        tx_reg, rx_meta_reg, rx_sync_reg;
  logic        tick;
  logic [2:0]  idx;
  logic        tx_push, rx_pop, ctrl_wr, baud_wr, irq_en_wr;
  logic [1:0]  w1c;
  logic [31:0] status_word;
  logic [3:0]  irq_stat;
  logic        thr_hit;
  logic        unused_bits;

  logic [DATA_W-1:0] tx_head;
  logic              tx_full, tx_empty, tx_pop;
  logic [TXL_W-1:0]  tx_level;
  logic [RXW-1:0]    rx_head, rx_word;
  logic              rx_full, rx_empty, rx_push;
  logic [RXL_W-1:0]  rx_level;

  tx_state_e         tx_state_reg, tx_state_next;
  logic [CNT_W-1:0]  tx_tick_reg, tx_tick_next;
  logic [BIT_W-1:0]  tx_bit_reg, tx_bit_next;
  logic [DATA_W-1:0] tx_shift_reg, tx_shift_next;
  logic              tx_par_reg, tx_par_next, tx_par_en_reg, tx_par_en_next;
  logic              tx_stop2_reg, tx_stop2_next, tx_stop_idx_reg, tx_stop_idx_next;
  logic              tx_line, tx_bit_end;

  rx_state_e         rx_state_reg, rx_state_next;
  logic [CNT_W-1:0]  rx_tick_reg, rx_tick_next;
  logic [BIT_W-1:0]  rx_bit_reg, rx_bit_next;
  logic [DATA_W-1:0] rx_shift_reg, rx_shift_next;
  logic              rx_par_err_reg, rx_par_err_next;
  logic              rx_sample;

  assign unused_bits = ^{addr[31:5], addr[1:0], w_data};
  assign idx         = addr[4:2];
  assign r_data      = r_data_reg;
  assign ready       = ready_reg;
  assign slverr      = slverr_reg;
  assign tx          = tx_reg;

  uart_sync_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .push_data(w_data[DATA_W-1:0]),
    .pop(tx_pop), .pop_data(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  uart_sync_fifo #(.W(RXW), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .push_data(rx_word),
    .pop(rx_pop), .pop_data(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  assign status_word = {8'b0, 8'(rx_level), 8'(tx_level), 4'b0, rx_empty, rx_full, tx_empty, tx_full};
  assign thr_hit     = (ctrl_reg.rx_thresh != 4'd0) && (32'(rx_level) >= 32'(ctrl_reg.rx_thresh));
  assign irq_stat    = {err_sticky_reg, ovr_sticky_reg, tx_empty, thr_hit};
  assign interrupt   = |(irq_stat & irq_en_reg);

  // Baud tick: one pulse every div+1 clocks, phase restarted by a BAUD write.
  assign tick = (baud_cnt_reg == baud_div_reg);

  always_comb begin
    r_data_next = '0;
    slverr_next = 1'b0;
    tx_push     = 1'b0;
    rx_pop      = 1'b0;
    ctrl_wr     = 1'b0;
    baud_wr     = 1'b0;
    irq_en_wr   = 1'b0;
    w1c         = 2'b00;
    if (w_en) begin
      case (idx)
        REG_CTRL:     ctrl_wr = 1'b1;
        REG_BAUD:     baud_wr = 1'b1;
        REG_TXDATA:   if (tx_full) slverr_next = 1'b1; else tx_push = 1'b1;
        REG_IRQ_EN:   irq_en_wr = 1'b1;
        REG_IRQ_STAT: w1c = w_data[3:2];
        default:      slverr_next = 1'b1;
      endcase
    end else if (r_en) begin
      case (idx)
        REG_CTRL:     r_data_next = ctrl_to_word(ctrl_reg);
        REG_BAUD:     r_data_next = {16'b0, baud_div_reg};
        REG_RXDATA: begin
          if (!rx_empty) begin
            rx_pop                   = 1'b1;
            r_data_next[31]          = 1'b1;
            r_data_next[17]          = rx_head[DATA_W+1];
            r_data_next[16]          = rx_head[DATA_W];
            r_data_next[DATA_W-1:0]  = rx_head[DATA_W-1:0];
          end
        end
        REG_STATUS:   r_data_next = status_word;
        REG_IRQ_EN:   r_data_next = {28'b0, irq_en_reg};
        REG_IRQ_STAT: r_data_next = {28'b0, irq_stat};
        default:      slverr_next = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_reg     <= '0;
      ready_reg      <= 1'b0;
      slverr_reg     <= 1'b0;
      ctrl_reg       <= '0;
      baud_div_reg   <= '0;
      baud_cnt_reg   <= '0;
      irq_en_reg     <= '0;
      ovr_sticky_reg <= 1'b0;
      err_sticky_reg <= 1'b0;
      rx_meta_reg    <= 1'b1;
      rx_sync_reg    <= 1'b1;
      tx_reg         <= 1'b1;
    end else begin
      r_data_reg  <= r_data_next;
      ready_reg   <= w_en || r_en;
      slverr_reg  <= slverr_next;
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      tx_reg      <= tx_line;
      if (ctrl_wr) begin
        ctrl_reg.rx_thresh <= w_data[11:8];
        ctrl_reg.stop2     <= w_data[4];
        ctrl_reg.par_odd   <= w_data[3];
        ctrl_reg.par_en    <= w_data[2];
        ctrl_reg.rx_en     <= w_data[1];
        ctrl_reg.tx_en     <= w_data[0];
      end
      if (baud_wr) baud_div_reg <= w_data[15:0];
      if (baud_wr || tick) baud_cnt_reg <= '0;
      else                 baud_cnt_reg <= baud_cnt_reg + 16'd1;
      if (irq_en_wr) irq_en_reg <= w_data[3:0];
      // A new event in the same cycle as a clear wins.
      ovr_sticky_reg <= (ovr_sticky_reg && !w1c[0]) || (rx_push && rx_full && !rx_pop);
      err_sticky_reg <= (err_sticky_reg && !w1c[1]) || (rx_push && (rx_word[DATA_W+1] || rx_word[DATA_W]));
    end
  end

  assign tx_bit_end = tick && (tx_tick_reg == BIT_LAST);

  always_comb begin
    tx_state_next    = tx_state_reg;
    tx_tick_next     = tx_tick_reg;
    tx_bit_next      = tx_bit_reg;
    tx_shift_next    = tx_shift_reg;
    tx_par_next      = tx_par_reg;
    tx_par_en_next   = tx_par_en_reg;
    tx_stop2_next    = tx_stop2_reg;
    tx_stop_idx_next = tx_stop_idx_reg;
    tx_pop           = 1'b0;
    tx_line          = 1'b1;
    if (tick) tx_tick_next = tx_bit_end ? '0 : tx_tick_reg + CNT_W'(1);
    case (tx_state_reg)
      TX_IDLE: begin
        tx_tick_next = '0;
        // Frame format is latched here so a CTRL write cannot corrupt a frame in flight.
        if (ctrl_reg.tx_en && !tx_empty) begin
          tx_pop           = 1'b1;
          tx_shift_next    = tx_head;
          tx_par_next      = (^tx_head) ^ ctrl_reg.par_odd;
          tx_par_en_next   = ctrl_reg.par_en;
          tx_stop2_next    = ctrl_reg.stop2;
          tx_stop_idx_next = 1'b0;
          tx_bit_next      = '0;
          tx_state_next    = TX_START;
        end
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_bit_end) tx_state_next = TX_DATA;
      end
      TX_DATA: begin
        tx_line = tx_shift_reg[0];
        if (tx_bit_end) begin
          tx_shift_next = tx_shift_reg >> 1;
          tx_bit_next   = tx_bit_reg + BIT_W'(1);
          if (tx_bit_reg == DATA_LAST) tx_state_next = tx_par_en_reg ? TX_PARITY : TX_STOP;
        end
      end
      TX_PARITY: begin
        tx_line = tx_par_reg;
        if (tx_bit_end) tx_state_next = TX_STOP;
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_stop2_reg && !tx_stop_idx_reg) tx_stop_idx_next = 1'b1;
          else                                  tx_state_next    = TX_IDLE;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_reg    <= TX_IDLE;
      tx_tick_reg     <= '0;
      tx_bit_reg      <= '0;
      tx_shift_reg    <= '0;
      tx_par_reg      <= 1'b0;
      tx_par_en_reg   <= 1'b0;
      tx_stop2_reg    <= 1'b0;
      tx_stop_idx_reg <= 1'b0;
    end else begin
      tx_state_reg    <= tx_state_next;
      tx_tick_reg     <= tx_tick_next;
      tx_bit_reg      <= tx_bit_next;
      tx_shift_reg    <= tx_shift_next;
      tx_par_reg      <= tx_par_next;
      tx_par_en_reg   <= tx_par_en_next;
      tx_stop2_reg    <= tx_stop2_next;
      tx_stop_idx_reg <= tx_stop_idx_next;
    end
  end

  // Start bit is checked half a bit in; every later sample lands mid-bit.
  assign rx_sample = tick && (rx_tick_reg == ((rx_state_reg == RX_START) ? MID_LAST : BIT_LAST));
  assign rx_word   = {!rx_sync_reg, rx_par_err_reg, rx_shift_reg};

  always_comb begin
    rx_state_next   = rx_state_reg;
    rx_tick_next    = rx_tick_reg;
    rx_bit_next     = rx_bit_reg;
    rx_shift_next   = rx_shift_reg;
    rx_par_err_next = rx_par_err_reg;
    rx_push         = 1'b0;
    if (tick) rx_tick_next = rx_sample ? '0 : rx_tick_reg + CNT_W'(1);
    case (rx_state_reg)
      RX_IDLE: begin
        rx_tick_next    = '0;
        rx_bit_next     = '0;
        rx_par_err_next = 1'b0;
        if (ctrl_reg.rx_en && !rx_sync_reg) rx_state_next = RX_START;
      end
      RX_START: begin
        if (rx_sample) rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_shift_next = {rx_sync_reg, rx_shift_reg[DATA_W-1:1]};
          rx_bit_next   = rx_bit_reg + BIT_W'(1);
          if (rx_bit_reg == DATA_LAST) rx_state_next = ctrl_reg.par_en ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (rx_sample) begin
          rx_par_err_next = rx_sync_reg != ((^rx_shift_reg) ^ ctrl_reg.par_odd);
          rx_state_next   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_sample) begin
          rx_push       = 1'b1;
          rx_state_next = rx_sync_reg ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (rx_sync_reg) rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_reg   <= RX_IDLE;
      rx_tick_reg    <= '0;
      rx_bit_reg     <= '0;
      rx_shift_reg   <= '0;
      rx_par_err_reg <= 1'b0;
    end else begin
      rx_state_reg   <= rx_state_next;
      rx_tick_reg    <= rx_tick_next;
      rx_bit_reg     <= rx_bit_next;
      rx_shift_reg   <= rx_shift_next;
      rx_par_err_reg <= rx_par_err_next;
    end
  end

endmodule

// File: tb/tb_uart_ctrl_param.sv
// Randomised self-checking bench for uart_ctrl_param: bus map, TX framing,
// RX framing and error flags, FIFO limits, interrupts and mid-frame reset.
module tb_uart_ctrl_param;
  localparam int OVS   = 16;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_en = 1'b0;
  logic        r_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] w_data = '0;
  logic [31:0] r_data;
  logic        ready, slverr, tx, rx, interrupt;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  assign rx = loop_en ? tx : rx_drv;
  always #5 clk = ~clk;

  uart_ctrl_param #(.DATA_W(8), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH), .OVS(OVS)) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .addr(addr), .w_data(w_data),
    .r_data(r_data), .ready(ready), .slverr(slverr), .tx(tx), .rx(rx), .interrupt(interrupt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, output logic err);
    @(posedge clk); #1;
    addr = a; w_data = d; w_en = 1'b1;
    @(posedge clk); #1;
    w_en = 1'b0;
    check_val("wr_ready", {31'b0, ready}, 32'd1);
    err = slverr;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic err);
    @(posedge clk); #1;
    addr = a; r_en = 1'b1;
    @(posedge clk); #1;
    r_en = 1'b0;
    check_val("rd_ready", {31'b0, ready}, 32'd1);
    d = r_data;
    err = slverr;
  endtask

  // Line-level view of a frame: start, LSB-first data, optional parity, stop bit(s).
  function automatic int frame_len(input bit pe, input bit s2);
    return 10 + int'(pe) + int'(s2);
  endfunction

  function automatic logic [31:0] frame_bits(input logic [7:0] d, input bit pe, input bit po, input bit s2);
    logic [31:0] f;
    int n;
    f = '0;
    for (int i = 0; i < 8; i++) f[1 + i] = d[i];
    n = 9;
    if (pe) begin
      f[n] = (($countones(d) % 2) == 1) ^ po;
      n++;
    end
    f[n] = 1'b1;
    if (s2) f[n + 1] = 1'b1;
    return f;
  endfunction

  task automatic capture_tx(input int period, input int nbits, output logic [31:0] bits);
    int waited;
    waited = 0;
    bits = '0;
    while (tx !== 1'b0 && waited < 4000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 4000) check_val("tx_start_timeout", {31'b0, tx}, 32'd0);
    repeat (period / 2) @(posedge clk);
    #1;
    for (int i = 0; i < nbits; i++) begin
      bits[i] = tx;
      repeat (period) @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_rx(input logic [7:0] d, input bit pe, input bit po, input bit bad_par, input bit stop_val);
    logic [31:0] f;
    int n;
    f = frame_bits(d, pe, po, 1'b0);
    n = frame_len(pe, 1'b0);
    if (pe && bad_par) f[9] = ~f[9];
    f[n - 1] = stop_val;
    for (int i = 0; i < n; i++) begin
      rx_drv = f[i];
      repeat (OVS) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
    repeat (2 * OVS) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd, bits, exp_w, cw;
    logic        err, err_m;
    logic [7:0]  d;
    bit          pe, po, s2, bp, sv;
    int          div, lvl;
    logic [31:0] q[$];

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_tx", {31'b0, tx}, 32'd1);
    check_val("rst_ready", {31'b0, ready}, 32'd0);
    check_val("rst_slverr", {31'b0, slverr}, 32'd0);
    check_val("rst_rdata", r_data, 32'd0);
    check_val("rst_irq", {31'b0, interrupt}, 32'd0);
    rst = 1'b0;
    bus_rd(32'h10, rd, err);
    check_val("rst_status", rd, 32'h0000_000A);
    bus_rd(32'h00, rd, err);
    check_val("rst_ctrl", rd, 32'd0);

    cw = $urandom;
    bus_wr(32'h00, cw, err);
    bus_rd(32'h00, rd, err);
    check_val("ctrl_readback", rd, cw & 32'h0000_0F1F);
    bus_wr(32'h00, 32'h0, err);

    // Fixed frame 0xA5, 8N1 at one tick per clock.
    bus_wr(32'h04, 32'd0, err);
    bus_wr(32'h00, 32'h1, err);
    bus_wr(32'h08, 32'hA5, err);
    capture_tx(OVS, 10, bits);
    check_val("tx_a5_frame", bits, frame_bits(8'hA5, 1'b0, 1'b0, 1'b0));

    for (int k = 0; k < 4; k++) begin
      div = $urandom_range(0, 3);
      pe = 1'($urandom); po = 1'($urandom); s2 = 1'($urandom);
      d = 8'($urandom);
      bus_wr(32'h04, 32'(div), err);
      bus_rd(32'h04, rd, err);
      check_val("baud_readback", rd, 32'(div));
      bus_wr(32'h00, (32'(s2) << 4) | (32'(po) << 3) | (32'(pe) << 2) | 32'h1, err);
      bus_wr(32'h08, {24'b0, d}, err);
      capture_tx((div + 1) * OVS, frame_len(pe, s2), bits);
      check_val("tx_rand_frame", bits, frame_bits(d, pe, po, s2));
    end

    // Reset in the middle of a frame returns the line high and drops queued data.
    bus_wr(32'h04, 32'd0, err);
    bus_wr(32'h00, 32'h1, err);
    bus_wr(32'h08, 32'h00, err);
    bus_wr(32'h08, 32'h66, err);
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check_val("midrst_tx", {31'b0, tx}, 32'd1);
    check_val("midrst_ready", {31'b0, ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus_rd(32'h10, rd, err);
    check_val("midrst_status", rd, 32'h0000_000A);
    repeat (200) @(posedge clk);
    #1;
    check_val("midrst_tx_idle", {31'b0, tx}, 32'd1);

    // Loopback with parity: first the fixed 0x3C odd-parity case, then random.
    loop_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        d = 8'h3C; pe = 1'b1; po = 1'b1;
      end else begin
        d = 8'($urandom); pe = 1'($urandom); po = 1'($urandom);
      end
      bus_wr(32'h00, (32'(po) << 3) | (32'(pe) << 2) | 32'h3, err);
      bus_wr(32'h08, {24'b0, d}, err);
      repeat (13 * OVS) @(posedge clk);
      #1;
      bus_rd(32'h0C, rd, err);
      check_val("loop_rxdata", rd, 32'h8000_0000 | {24'b0, d});
    end
    loop_en = 1'b0;

    // Driven frames with random parity/stop faults; flags follow the line contents.
    bus_wr(32'h08 + 32'h0C, 32'h8, err);
    err_m = 1'b0;
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom); pe = 1'($urandom); po = 1'($urandom);
      bp = 1'($urandom); sv = ($urandom_range(0, 2) != 0);
      bus_wr(32'h00, (32'(po) << 3) | (32'(pe) << 2) | 32'h2, err);
      drive_rx(d, pe, po, bp, sv);
      exp_w = 32'h8000_0000 | {24'b0, d} | (32'(!sv) << 17) | (32'(pe && bp) << 16);
      if (!sv || (pe && bp)) err_m = 1'b1;
      bus_rd(32'h0C, rd, err);
      check_val("rx_rand_word", rd, exp_w);
      check_val("rx_rand_slverr", {31'b0, err}, 32'd0);
    end
    bus_rd(32'h18, rd, err);
    check_val("rx_rand_irqstat", rd, (32'(err_m) << 3) | 32'h2);
    bus_wr(32'h18, 32'hC, err);
    bus_rd(32'h18, rd, err);
    check_val("irqstat_cleared", rd, 32'h2);

    d = 8'($urandom);
    bus_wr(32'h00, 32'h2, err);
    drive_rx(d, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_rd(32'h18, rd, err);
    check_val("frm_irqstat", rd, 32'hA);
    check_val("frm_interrupt", {31'b0, interrupt}, 32'd1);
    bus_rd(32'h0C, rd, err);
    check_val("frm_rxdata", rd, 32'h8002_0000 | {24'b0, d});
    bus_wr(32'h18, 32'h8, err);
    bus_rd(32'h18, rd, err);
    check_val("frm_w1c", rd, 32'h2);
    check_val("frm_irq_low", {31'b0, interrupt}, 32'd0);

    // Overrun: one more frame than the RX FIFO holds, threshold interrupt at 5.
    bus_wr(32'h00, 32'h0000_0502, err);
    bus_wr(32'h14, 32'h1, err);
    q.delete();
    for (int k = 0; k <= DEPTH; k++) begin
      d = 8'($urandom);
      drive_rx(d, 1'b0, 1'b0, 1'b0, 1'b1);
      if (q.size() < DEPTH) q.push_back(32'h8000_0000 | {24'b0, d});
      lvl = q.size();
      bus_rd(32'h18, rd, err);
      check_val("thr_live", rd & 32'h1, 32'(lvl >= 5));
      check_val("thr_interrupt", {31'b0, interrupt}, 32'(lvl >= 5));
    end
    bus_rd(32'h10, rd, err);
    check_val("ovr_status", rd, 32'h0010_0006);
    bus_rd(32'h18, rd, err);
    check_val("ovr_irqstat", rd, 32'h7);
    for (int k = 0; k <= DEPTH; k++) begin
      bus_rd(32'h0C, rd, err);
      exp_w = (q.size() > 0) ? q.pop_front() : 32'd0;
      check_val("ovr_rxdata", rd, exp_w);
      check_val("ovr_rd_slverr", {31'b0, err}, 32'd0);
    end

    // Short low glitch must be rejected as a false start.
    rx_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_drv = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    bus_rd(32'h10, rd, err);
    check_val("glitch_status", rd, 32'h0000_000A);

    // TX FIFO overflow with transmitter disabled, then illegal accesses.
    bus_wr(32'h00, 32'h0, err);
    for (int k = 0; k <= DEPTH; k++) begin
      bus_wr(32'h08, $urandom, err);
      check_val("txfill_slverr", {31'b0, err}, 32'(k == DEPTH));
    end
    bus_rd(32'h10, rd, err);
    check_val("txfull_status", rd, 32'h0000_1009);
    bus_rd(32'h1C, rd, err);
    check_val("bad_addr_slverr", {31'b0, err}, 32'd1);
    check_val("bad_addr_rdata", rd, 32'd0);
    bus_wr(32'h0C, 32'hFFFF_FFFF, err);
    check_val("wr_ro_slverr", {31'b0, err}, 32'd1);
    bus_rd(32'h08, rd, err);
    check_val("rd_wo_slverr", {31'b0, err}, 32'd1);
    bus_wr(32'h10, 32'hFFFF_FFFF, err);
    bus_rd(32'h00, rd, err);
    check_val("ctrl_untouched", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
